// File: rtl/afg_pkg.sv
// afg_pkg
//   Shared definitions for the shadow register bank.
//   - state_t        : commit sequencer state encoding (IDLE=0, ARMED=1, APPLY=2)
//   - chan_idx_width : channel index width, max(1, clog2(channels))
package afg_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      APPLY = 2'd2
   } state_t;

   // A single-channel bank still needs a 1-bit index port.
   function automatic int chan_idx_width(input int channels);
      return (channels > 1) ? $clog2(channels) : 1;
   endfunction

endpackage

// File: rtl/param_chan_reg.sv
// param_chan_reg
//   One channel of the shadow register bank: a shadow register loaded by
//   writes, an active register loaded from the shadow on apply, and a dirty
//   flag marking a shadow that has not yet been committed.
// Ports:
//   Clock   in   system clock, rising edge
//   Reset   in   synchronous, active-low; clears shadow, active and dirty
//   wr      in   load wr_data into shadow and mark dirty
//   wr_data in   WIDTH-bit value for the shadow register
//   apply   in   commit edge: shadow -> active if dirty, then clear dirty
//   active  out  WIDTH-bit committed value (registered)
//   dirty   out  shadow differs from last commit
module param_chan_reg #(
   parameter int WIDTH = 16
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             wr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             apply,
   output logic [WIDTH-1:0] active,
   output logic             dirty
);

   logic [WIDTH-1:0] shadow;

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         shadow <= '0;
         active <= '0;
         dirty  <= 1'b0;
      end else begin
         if (wr)
            shadow <= wr_data;
         // Apply takes the pre-edge shadow, so a write landing on the same
         // edge is kept for the next commit and leaves the channel dirty.
         if (apply && dirty)
            active <= shadow;
         if (wr)
            dirty <= 1'b1;
         else if (apply)
            dirty <= 1'b0;
      end
   end

endmodule

// File: rtl/param_shadow_regbank.sv
// param_shadow_regbank
//   Bank of CHANNELS double-buffered registers. Writes go to per-channel
//   shadow registers at any time; a commit request transfers all dirty
//   shadows to the active outputs either at the next sync_pulse (waveform
//   period boundary) or immediately.
// Ports:
//   Clock       in   system clock, rising edge
//   Reset       in   synchronous, active-low
//   wr_en       in   write shadow[wr_ch] this cycle
//   wr_ch       in   CH_W-bit channel index; indices >= CHANNELS are ignored
//   wr_data     in   WIDTH-bit shadow value
//   commit_req  in   request transfer of dirty shadows (ignored while busy)
//   immediate   in   with commit_req: apply without waiting for sync_pulse
//   sync_pulse  in   period boundary strobe, honoured only while ARMED
//   Dout        out  active registers, channel k at [k*WIDTH +: WIDTH]
//   dirty       out  per-channel shadow-not-committed flags
//   busy        out  commit sequencer not IDLE
//   commit_done out  one-cycle pulse coincident with updated Dout
module param_shadow_regbank
   import afg_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 4,
   localparam int CH_W    = chan_idx_width(CHANNELS)
) (
   input  logic                      Clock,
   input  logic                      Reset,
   input  logic                      wr_en,
   input  logic [CH_W-1:0]           wr_ch,
   input  logic [WIDTH-1:0]          wr_data,
   input  logic                      commit_req,
   input  logic                      immediate,
   input  logic                      sync_pulse,
   output logic [CHANNELS*WIDTH-1:0] Dout,
   output logic [CHANNELS-1:0]       dirty,
   output logic                      busy,
   output logic                      commit_done
);

   state_t state, state_nxt;
   logic   apply;

   // Commit sequencer state register.
   always_ff @(posedge Clock) begin
      if (!Reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next state. commit_req is only looked at in IDLE, so requests arriving
   // while a commit is pending are dropped rather than queued.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (commit_req)
               state_nxt = immediate ? APPLY : ARMED;
         end
         ARMED: begin
            if (sync_pulse)
               state_nxt = APPLY;
         end
         APPLY: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign apply = (state == APPLY);
   assign busy  = (state != IDLE);

   // The done pulse follows the APPLY edge, lining up with the new Dout.
   always_ff @(posedge Clock) begin
      if (!Reset)
         commit_done <= 1'b0;
      else
         commit_done <= apply;
   end

   // Per-channel decode compares against each in-range index only, so an
   // out-of-range wr_ch simply hits no channel.
   for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
      logic wr_hit;

      assign wr_hit = wr_en && (wr_ch == CH_W'(k));

      param_chan_reg #(
         .WIDTH (WIDTH)
      ) u_chan (
         .Clock   (Clock),
         .Reset   (Reset),
         .wr      (wr_hit),
         .wr_data (wr_data),
         .apply   (apply),
         .active  (Dout[k*WIDTH +: WIDTH]),
         .dirty   (dirty[k])
      );
   end

endmodule

// File: tb/tb_param_shadow_regbank.sv
module tb_param_shadow_regbank;

   logic        Clock;
   logic        Reset;
   logic        wr_en;
   logic [1:0]  wr_ch;
   logic [15:0] wr_data;
   logic        commit_req;
   logic        immediate;
   logic        sync_pulse;

   logic [63:0] dout4;
   logic [3:0]  dirty4;
   logic        busy4, done4;
   logic [47:0] dout3;
   logic [2:0]  dirty3;
   logic        busy3, done3;

   int n_cmp = 0;
   int n_bad = 0;

   param_shadow_regbank #(.WIDTH(16), .CHANNELS(4)) dut4 (
      .Clock(Clock), .Reset(Reset), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
      .commit_req(commit_req), .immediate(immediate), .sync_pulse(sync_pulse),
      .Dout(dout4), .dirty(dirty4), .busy(busy4), .commit_done(done4));

   param_shadow_regbank #(.WIDTH(16), .CHANNELS(3)) dut3 (
      .Clock(Clock), .Reset(Reset), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
      .commit_req(commit_req), .immediate(immediate), .sync_pulse(sync_pulse),
      .Dout(dout3), .dirty(dirty3), .busy(busy3), .commit_done(done3));

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // ---------------- reference model ----------------
   // Index 0 models the 4-channel bank, index 1 the 3-channel bank.
   int          nch [2] = '{4, 3};
   logic [15:0] m_sh  [2][4];
   logic [15:0] m_act [2][4];
   bit          m_dirty [2][4];
   bit          m_waiting;   // commit requested, waiting for sync
   bit          m_applying;  // commit takes effect on the next edge
   bit          m_done;

   task automatic model_edge();
      if (!Reset) begin
         for (int m = 0; m < 2; m++)
            for (int k = 0; k < 4; k++) begin
               m_sh[m][k] = '0; m_act[m][k] = '0; m_dirty[m][k] = 0;
            end
         m_waiting = 0; m_applying = 0; m_done = 0;
         return;
      end
      m_done = m_applying;
      for (int m = 0; m < 2; m++)
         for (int k = 0; k < nch[m]; k++) begin
            if (m_applying && m_dirty[m][k]) begin
               m_act[m][k]   = m_sh[m][k];
               m_dirty[m][k] = 0;
            end
            if (wr_en && int'(wr_ch) == k) begin
               m_sh[m][k]    = wr_data;
               m_dirty[m][k] = 1;
            end
         end
      if (m_applying)
         m_applying = 0;
      else if (m_waiting) begin
         if (sync_pulse) begin m_waiting = 0; m_applying = 1; end
      end else if (commit_req) begin
         if (immediate) m_applying = 1;
         else           m_waiting  = 1;
      end
   endtask

   function automatic logic [63:0] exp_dout4();
      logic [63:0] r;
      for (int k = 0; k < 4; k++) r[k*16 +: 16] = m_act[0][k];
      return r;
   endfunction

   function automatic logic [47:0] exp_dout3();
      logic [47:0] r;
      for (int k = 0; k < 3; k++) r[k*16 +: 16] = m_act[1][k];
      return r;
   endfunction

   function automatic logic [3:0] exp_dirty4();
      logic [3:0] r;
      for (int k = 0; k < 4; k++) r[k] = m_dirty[0][k];
      return r;
   endfunction

   function automatic logic [2:0] exp_dirty3();
      logic [2:0] r;
      for (int k = 0; k < 3; k++) r[k] = m_dirty[1][k];
      return r;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic idle_inputs();
      wr_en = 0; wr_ch = '0; wr_data = '0;
      commit_req = 0; immediate = 0; sync_pulse = 0;
   endtask

   // Advance one clock: model follows the sampled inputs, then outputs settle.
   task automatic tick();
      @(posedge Clock);
      model_edge();
      #1;
   endtask

   task automatic do_write(input logic [1:0] ch, input logic [15:0] d);
      wr_en = 1; wr_ch = ch; wr_data = d;
      tick();
      wr_en = 0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      idle_inputs();
      Reset = 0;
      tick(); tick();
      Reset = 1;
      n_cmp++; if (dout4 !== 64'h0) begin n_bad++; $display("FAIL reset_dout4 got %h want 0", dout4); end
      n_cmp++; if (dout3 !== 48'h0) begin n_bad++; $display("FAIL reset_dout3 got %h want 0", dout3); end
      n_cmp++; if (dirty4 !== 4'h0 || dirty3 !== 3'h0) begin n_bad++; $display("FAIL reset_dirty got %b/%b want 0", dirty4, dirty3); end
      n_cmp++; if (busy4 !== 1'b0 || done4 !== 1'b0) begin n_bad++; $display("FAIL reset_busy_done got %b/%b want 0/0", busy4, done4); end
   endtask

   task automatic test_sync_commit();
      int pulses = 0;
      do_write(2'd0, 16'h1234);
      do_write(2'd2, 16'hBEEF);
      n_cmp++; if (dirty4 !== 4'b0101) begin n_bad++; $display("FAIL sync_dirty_pre got %b want 0101", dirty4); end
      commit_req = 1; immediate = 0;
      tick();
      commit_req = 0;
      n_cmp++; if (busy4 !== 1'b1) begin n_bad++; $display("FAIL sync_armed_busy got %b want 1", busy4); end
      for (int i = 0; i < 4; i++) begin
         tick();
         if (done4) pulses++;
      end
      n_cmp++; if (dout4 !== 64'h0) begin n_bad++; $display("FAIL sync_hold_dout got %h want 0", dout4); end
      sync_pulse = 1;
      tick();
      sync_pulse = 0;
      if (done4) pulses++;
      n_cmp++; if (dout4 !== 64'h0) begin n_bad++; $display("FAIL sync_apply_latency got %h want 0", dout4); end
      tick();
      n_cmp++; if (dout4 !== 64'h0000_BEEF_0000_1234) begin n_bad++; $display("FAIL sync_dout4 got %h want 0000beef00001234", dout4); end
      n_cmp++; if (dout3 !== 48'hBEEF_0000_1234) begin n_bad++; $display("FAIL sync_dout3 got %h want beef00001234", dout3); end
      n_cmp++; if (done4 !== 1'b1 || dirty4 !== 4'b0000) begin n_bad++; $display("FAIL sync_done_dirty got %b/%b want 1/0000", done4, dirty4); end
      pulses++;
      tick();
      if (done4) pulses++;
      tick();
      if (done4) pulses++;
      n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL sync_done_count got %0d want 1", pulses); end
      n_cmp++; if (busy4 !== 1'b0) begin n_bad++; $display("FAIL sync_idle_busy got %b want 0", busy4); end
   endtask

   task automatic test_immediate();
      do_write(2'd3, 16'h00FF);
      commit_req = 1; immediate = 1;
      tick();
      commit_req = 0; immediate = 0;
      n_cmp++; if (dout4[63:48] !== 16'h0000) begin n_bad++; $display("FAIL imm_early got %h want 0000", dout4[63:48]); end
      tick();
      n_cmp++; if (dout4 !== 64'h00FF_BEEF_0000_1234) begin n_bad++; $display("FAIL imm_dout4 got %h want 00ffbeef00001234", dout4); end
      n_cmp++; if (done4 !== 1'b1 || done3 !== 1'b1) begin n_bad++; $display("FAIL imm_done got %b/%b want 1/1", done4, done3); end
      n_cmp++; if (dout3 !== 48'hBEEF_0000_1234 || dirty3 !== 3'b000) begin n_bad++; $display("FAIL imm_dout3 got %h/%b want beef00001234/000", dout3, dirty3); end
   endtask

   task automatic test_apply_collision();
      do_write(2'd1, 16'hAAAA);
      commit_req = 1; immediate = 0;
      tick();
      commit_req = 0;
      sync_pulse = 1;
      tick();
      sync_pulse = 0;
      do_write(2'd1, 16'h5555);
      n_cmp++; if (dout4[31:16] !== 16'hAAAA) begin n_bad++; $display("FAIL coll_dout got %h want aaaa", dout4[31:16]); end
      n_cmp++; if (dirty4 !== 4'b0010 || done4 !== 1'b1) begin n_bad++; $display("FAIL coll_dirty_done got %b/%b want 0010/1", dirty4, done4); end
      commit_req = 1; immediate = 1;
      tick();
      commit_req = 0; immediate = 0;
      tick();
      n_cmp++; if (dout4[31:16] !== 16'h5555 || dirty4 !== 4'b0000) begin n_bad++; $display("FAIL coll_second got %h/%b want 5555/0000", dout4[31:16], dirty4); end
   endtask

   task automatic test_reset_armed();
      int pulses = 0;
      do_write(2'd0, 16'h7777);
      commit_req = 1; immediate = 0;
      tick();
      commit_req = 0;
      Reset = 0;
      tick();
      Reset = 1;
      n_cmp++; if (dout4 !== 64'h0 || dirty4 !== 4'h0 || busy4 !== 1'b0) begin n_bad++; $display("FAIL rstarm_state got %h/%b/%b want 0/0/0", dout4, dirty4, busy4); end
      sync_pulse = 1;
      tick();
      sync_pulse = 0;
      if (done4) pulses++;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (done4 || busy4) pulses++;
      end
      n_cmp++; if (pulses != 0 || dout4 !== 64'h0) begin n_bad++; $display("FAIL rstarm_sync_ignored got %0d/%h want 0/0", pulses, dout4); end
   endtask

   task automatic test_invalid_channel();
      int pulses = 0;
      do_write(2'd3, 16'h9999);
      n_cmp++; if (dirty3 !== 3'b000) begin n_bad++; $display("FAIL inv_dirty3 got %b want 000", dirty3); end
      n_cmp++; if (dirty4 !== 4'b1000) begin n_bad++; $display("FAIL inv_dirty4 got %b want 1000", dirty4); end
      commit_req = 1; immediate = 0;
      tick();
      // repeated requests while armed must not queue a second commit
      immediate = 1;
      tick(); tick();
      commit_req = 0; immediate = 0;
      sync_pulse = 1;
      tick();
      sync_pulse = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (done3) pulses++;
      end
      n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL inv_done_count got %0d want 1", pulses); end
      n_cmp++; if (dout3 !== 48'h0) begin n_bad++; $display("FAIL inv_dout3 got %h want 0", dout3); end
      n_cmp++; if (dout4 !== 64'h9999_0000_0000_0000) begin n_bad++; $display("FAIL inv_dout4 got %h want 9999000000000000", dout4); end
   endtask

   task automatic test_random();
      for (int cyc = 0; cyc < 600; cyc++) begin
         Reset      = ($urandom_range(0, 59) != 0);
         wr_en      = ($urandom_range(0, 2) == 0);
         wr_ch      = 2'($urandom_range(0, 3));
         wr_data    = 16'($urandom);
         commit_req = ($urandom_range(0, 5) == 0);
         immediate  = ($urandom_range(0, 2) == 0);
         sync_pulse = ($urandom_range(0, 4) == 0);
         tick();
         n_cmp++; if (dout4 !== exp_dout4()) begin n_bad++; $display("FAIL rand_dout4 cyc %0d got %h want %h", cyc, dout4, exp_dout4()); end
         n_cmp++; if (dout3 !== exp_dout3()) begin n_bad++; $display("FAIL rand_dout3 cyc %0d got %h want %h", cyc, dout3, exp_dout3()); end
         n_cmp++; if (dirty4 !== exp_dirty4() || dirty3 !== exp_dirty3()) begin n_bad++; $display("FAIL rand_dirty cyc %0d got %b/%b want %b/%b", cyc, dirty4, dirty3, exp_dirty4(), exp_dirty3()); end
         n_cmp++; if (busy4 !== (m_waiting || m_applying) || busy3 !== busy4) begin n_bad++; $display("FAIL rand_busy cyc %0d got %b/%b want %b", cyc, busy4, busy3, m_waiting || m_applying); end
         n_cmp++; if (done4 !== m_done || done3 !== m_done) begin n_bad++; $display("FAIL rand_done cyc %0d got %b/%b want %b", cyc, done4, done3, m_done); end
      end
      idle_inputs();
      Reset = 1;
   endtask

   initial begin
      Reset = 0;
      idle_inputs();
      test_reset();
      test_sync_commit();
      test_immediate();
      test_apply_collision();
      test_reset_armed();
      test_invalid_channel();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
